// File: rtl/axis_scaled_multiplier.sv
// rtl/axis_scaled_multiplier.sv - joined two-stream signed multiplier with round, shift and saturate
module axis_scaled_multiplier #(
    parameter int S00Size  = 16,
    parameter int S01Size  = 16,
    parameter int MSize    = 16,
    parameter int SHIFT    = 15,
    parameter int ROUND    = 1,
    parameter int SATURATE = 1,
    parameter int PIPE     = 2
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [S00Size-1:0] s00_axis_tdata,
    input  logic               s00_axis_tvalid,
    output logic               s00_axis_tready,
    input  logic [S01Size-1:0] s01_axis_tdata,
    input  logic               s01_axis_tvalid,
    output logic               s01_axis_tready,
    output logic [MSize-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    input  logic               sat_clear,
    output logic [15:0]        sat_count
);
    localparam int PW  = S00Size + S01Size;
    localparam int RW  = PW + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? (RW'(1) <<< RSH) : '0;
    localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (MSize - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = -(RW'(1) <<< (MSize - 1));

    logic                 en;
    logic                 accept;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q [PIPE];
    logic [PIPE-1:0]      vld_q;
    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [MSize-1:0]     res;
    logic [15:0]          sat_count_q;
    logic [15:0]          sat_count_d;

    // The output stage valid doubles as the stall condition for the whole pipe.
    assign m_axis_tvalid   = vld_q[PIPE-1] & ~areset;
    assign en              = ~m_axis_tvalid | m_axis_tready;
    assign accept          = en & s00_axis_tvalid & s01_axis_tvalid & ~areset;
    assign s00_axis_tready = accept;
    assign s01_axis_tready = accept;

    always_comb begin
        a_ext  = PW'($signed(s00_axis_tdata));
        b_ext  = PW'($signed(s01_axis_tdata));
        prod_d = a_ext * b_ext;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                prod_q[i] <= '0;
            end
        end else if (en) begin
            vld_q[0]  <= accept;
            prod_q[0] <= prod_d;
            for (int i = 1; i < PIPE; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Scaling works on the held last stage, so stalled output data cannot change.
    always_comb begin
        rounded = RW'(prod_q[PIPE-1]) + RND;
        shifted = rounded >>> SHIFT;
        sat_hi  = (SATURATE != 0) && (shifted > MAXV);
        sat_lo  = (SATURATE != 0) && (shifted < MINV);
        if (sat_hi) begin
            res = MAXV[MSize-1:0];
        end else if (sat_lo) begin
            res = MINV[MSize-1:0];
        end else begin
            res = shifted[MSize-1:0];
        end
    end

    assign m_axis_tdata = areset ? '0 : res;

    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (m_axis_tvalid && m_axis_tready && (sat_hi || sat_lo) && sat_count_q != 16'hFFFF) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = areset ? 16'd0 : sat_count_q;
endmodule

// File: tb/tb_axis_scaled_multiplier.sv
// tb/tb_axis_scaled_multiplier.sv - self-checking bench for axis_scaled_multiplier
module tb_axis_scaled_multiplier;
    localparam int AW = 16, BW = 16, MW = 16, SHIFT = 15, ROUND = 1, SATURATE = 1, PIPE = 2;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] s00_tdata;
    logic          s00_tvalid, s00_tready;
    logic [BW-1:0] s01_tdata;
    logic          s01_tvalid, s01_tready;
    logic [MW-1:0] m_tdata;
    logic          m_tvalid, m_tready;
    logic          sat_clear;
    logic [15:0]   sat_count;

    axis_scaled_multiplier #(
        .S00Size(AW), .S01Size(BW), .MSize(MW), .SHIFT(SHIFT),
        .ROUND(ROUND), .SATURATE(SATURATE), .PIPE(PIPE)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s00_axis_tdata(s00_tdata), .s00_axis_tvalid(s00_tvalid), .s00_axis_tready(s00_tready),
        .s01_axis_tdata(s01_tdata), .s01_axis_tvalid(s01_tvalid), .s01_axis_tready(s01_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .sat_clear(sat_clear), .sat_count(sat_count)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [15:0] d; bit sat; int cyc; } exp_t;
    typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] d; bit sat; } vec_t;

    exp_t        q[$];
    vec_t        vecs[12];
    int          n_tests = 0, n_fail = 0, cyc = 0, n_out = 0, lat = 0, n_acc = 0, n_out0 = 0;
    logic [15:0] model_sat = 16'd0, out_d = 16'd0, prev_data = 16'd0;
    bit          hs_in = 0, hs_out = 0, prev_stall = 0, done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint p, r, hi, lo;
        p = longint'($signed(a)) * longint'($signed(b));
        if (ROUND != 0 && SHIFT > 0) p = p + (longint'(1) << (SHIFT - 1));
        r  = p >>> SHIFT;
        hi = (longint'(1) << (MW - 1)) - 1;
        lo = -(hi + 1);
        e.sat = 0;
        e.cyc = 0;
        if (SATURATE != 0 && r > hi) begin
            r = hi; e.sat = 1;
        end else if (SATURATE != 0 && r < lo) begin
            r = lo; e.sat = 1;
        end
        e.d = 16'(r);
        return e;
    endfunction

    // One clock cycle: observe mid-cycle, update the scoreboard, then advance to edge+1.
    task automatic step();
        exp_t e;
        logic exp_rdy;
        #4;
        cyc++;
        hs_in  = 0;
        hs_out = 0;
        if (areset) begin
            q.delete();
            model_sat  = 16'd0;
            prev_stall = 0;
        end else begin
            exp_rdy = (!m_tvalid || m_tready) && s00_tvalid && s01_tvalid;
            chk("join_ready", 32'({s00_tready, s01_tready}), 32'({exp_rdy, exp_rdy}));
            chk("sat_count", 32'(sat_count), 32'(model_sat));
            if (prev_stall) begin
                chk("stall_valid", 32'(m_tvalid), 32'(1'b1));
                chk("stall_data", 32'(m_tdata), 32'(prev_data));
            end
            e.sat = 0;
            if (m_tvalid && m_tready) begin
                hs_out = 1;
                n_out++;
                out_d  = m_tdata;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(m_tdata), 32'hDEAD_BEEF);
                end else begin
                    e = q.pop_front();
                    chk("stream_data", 32'(m_tdata), 32'(e.d));
                    lat = cyc - e.cyc;
                end
            end
            if (sat_clear) model_sat = 16'd0;
            else if (hs_out && e.sat && model_sat != 16'hFFFF) model_sat = model_sat + 16'd1;
            if (s00_tready && s01_tready) begin
                hs_in = 1;
                n_acc++;
                e     = model(s00_tdata, s01_tdata);
                e.cyc = cyc;
                q.push_back(e);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        s00_tdata = a; s01_tdata = b; s00_tvalid = 1; s01_tvalid = 1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = hs_in;
        end
        s00_tvalid = 0; s01_tvalid = 0;
        if (!done) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_out();
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = hs_out;
        end
        if (!done) chk("output_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        vecs[0]  = '{16'h4000, 16'h4000, 16'h2000, 1'b0};
        vecs[1]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1};
        vecs[2]  = '{16'h0001, 16'h4000, 16'h0001, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h4000, 16'h0000, 1'b0};
        vecs[4]  = '{16'h7FFF, 16'h7FFF, 16'h7FFE, 1'b0};
        vecs[5]  = '{16'h8000, 16'h7FFF, 16'h8001, 1'b0};
        vecs[6]  = '{16'hC000, 16'h4000, 16'hE000, 1'b0};
        vecs[7]  = '{16'h0001, 16'h3FFF, 16'h0000, 1'b0};
        vecs[8]  = '{16'hFFFF, 16'hC000, 16'h0001, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8001, 16'h7FFF, 1'b0};
        vecs[10] = '{16'h0003, 16'h4000, 16'h0002, 1'b0};
        vecs[11] = '{16'hFFFD, 16'h4000, 16'hFFFF, 1'b0};

        areset = 1; s00_tvalid = 1; s01_tvalid = 1; s00_tdata = 16'h1234; s01_tdata = 16'h5678;
        m_tready = 1; sat_clear = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'(1'b0));
        chk("rst_tdata", 32'(m_tdata), 32'(16'h0));
        chk("rst_tready", 32'({s00_tready, s01_tready}), 32'(2'b00));
        chk("rst_sat", 32'(sat_count), 32'(16'h0));
        s00_tvalid = 0; s01_tvalid = 0;
        areset = 0;
        step();

        foreach (vecs[i]) begin
            send_pair(vecs[i].a, vecs[i].b);
            wait_out();
            chk("vec_data", 32'(out_d), 32'(vecs[i].d));
            chk("vec_latency", 32'(lat), 32'(PIPE));
        end
        chk("sat_after_table", 32'(sat_count), 32'(16'd1));
        sat_clear = 1;
        step();
        sat_clear = 0;
        chk("sat_cleared", 32'(sat_count), 32'(16'd0));

        // Clear coinciding with a saturated output handshake must win.
        send_pair(16'h8000, 16'h8000);
        step();
        sat_clear = 1;
        step();
        sat_clear = 0;
        chk("clr_cycle_handshake", 32'(hs_out), 32'(1'b1));
        chk("clr_priority", 32'(sat_count), 32'(16'd0));

        // Lone valid on A must not be consumed while B is absent.
        s00_tdata = 16'h2000; s00_tvalid = 1; s01_tdata = 16'h6000; s01_tvalid = 0;
        n_out0 = n_out;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lone_no_accept", 32'(hs_in), 32'(1'b0));
        end
        s01_tvalid = 1;
        done = 0;
        for (int i = 0; i < 5 && !done; i++) begin
            step();
            done = hs_in;
        end
        chk("join_accepted", 32'(done), 32'(1'b1));
        s00_tvalid = 0; s01_tvalid = 0;
        repeat (6) step();
        chk("join_one_output", 32'(n_out - n_out0), 32'(1));

        // Random stream with random backpressure; AXIS-style hold of offered data.
        n_acc = 0;
        n_out0 = n_out;
        for (int i = 0; i < 600 && n_acc < 40; i++) begin
            if (!s00_tvalid || hs_in) begin
                s00_tdata = 16'($urandom); s00_tvalid = ($urandom_range(3) != 0);
            end
            if (!s01_tvalid || hs_in) begin
                s01_tdata = 16'($urandom); s01_tvalid = ($urandom_range(3) != 0);
            end
            m_tready = $urandom_range(1);
            step();
        end
        s00_tvalid = 0; s01_tvalid = 0; m_tready = 1;
        repeat (8) step();
        chk("rand_accepted", 32'(n_acc >= 8), 32'(1'b1));
        chk("rand_drained", 32'(q.size()), 32'(0));
        chk("rand_outputs", 32'(n_out - n_out0), 32'(n_acc));

        // Reset with two beats in flight discards them.
        s00_tdata = 16'h4000; s01_tdata = 16'h4000; s00_tvalid = 1; s01_tvalid = 1;
        step();
        s00_tdata = 16'h7FFF; s01_tdata = 16'h1000;
        step();
        s00_tvalid = 0; s01_tvalid = 0;
        areset = 1;
        #2;
        chk("rst_mid_tvalid", 32'(m_tvalid), 32'(1'b0));
        chk("rst_mid_tdata", 32'(m_tdata), 32'(16'h0));
        step();
        step();
        areset = 0;
        n_out0 = n_out;
        repeat (4) step();
        chk("rst_no_stale_out", 32'(n_out - n_out0), 32'(0));
        send_pair(16'h4000, 16'h2000);
        wait_out();
        chk("post_rst_data", 32'(out_d), 32'(16'h1000));
        chk("post_rst_latency", 32'(lat), 32'(PIPE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
